// File: rtl/axi4lite_reg_pkg.sv
// rtl/axi4lite_reg_pkg.sv - shared response codes, channel FSM states and register stride
package axi4lite_reg_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int REG_STRIDE = 4;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

endpackage

// File: rtl/axi4lite_reg_slave_if.sv
// rtl/axi4lite_reg_slave_if.sv - AXI4-Lite bus bundle with master/slave views
interface axi4lite_reg_slave_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4lite_reg_bank.sv
// rtl/axi4lite_reg_bank.sv - register array with byte-strobe write and combinational read mux
module axi4lite_reg_bank #(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic [IDX_W-1:0]      ridx,
    output logic [31:0]           rdata,
    output logic [NUM_REGS*32-1:0] regs
);

    logic [31:0] mem [NUM_REGS];

    // Indices past NUM_REGS match no slot, so stray writes drop and stray reads give 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                mem[k] <= '0;
            end
        end else if (we) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (widx == IDX_W'(k)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wstrb[b]) begin
                            mem[k][8*b +: 8] <= wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (ridx == IDX_W'(k)) begin
                rdata = mem[k];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
        assign regs[32*g +: 32] = mem[g];
    end

endmodule

// File: rtl/axi4lite_reg_slave.sv
// rtl/axi4lite_reg_slave.sv - AXI4-Lite register slave; AXI4LITE_REG_SLAVE_SLVERR_EN makes decode misses answer SLVERR
import axi4lite_reg_pkg::*;

module axi4lite_reg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS           = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    axi4lite_reg_slave_if.slave     s_axi,
    output logic [NUM_REGS*32-1:0]  regs_o
);

    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int IDX_W = AW - 2;
    localparam logic [AW:0] ADDR_LIMIT = (AW+1)'(REG_STRIDE * NUM_REGS);

`ifdef AXI4LITE_REG_SLAVE_SLVERR_EN
    localparam logic [1:0] MISS_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] MISS_RESP = RESP_OKAY;
`endif

    function automatic logic [1:0] resp_for(input logic [AW-1:0] addr);
        return ({1'b0, addr} < ADDR_LIMIT) ? RESP_OKAY : MISS_RESP;
    endfunction

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic                          aw_done, w_done;
    logic [AW-1:0]                 awaddr_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
    logic [3:0]                    wstrb_q;
    logic [1:0]                    bresp_q;
    logic                          aw_fire, w_fire, ar_fire, commit;
    logic [AW-1:0]                 wr_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
    logic [3:0]                    wr_strb;
    logic [C_S_AXI_DATA_WIDTH-1:0] bank_rdata;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                    rresp_q;

    logic unused_prot;
    assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

    // A channel captured in an earlier cycle takes precedence over the live bus.
    assign wr_addr = aw_done ? awaddr_q : s_axi.awaddr;
    assign wr_data = w_done  ? wdata_q  : s_axi.wdata;
    assign wr_strb = w_done  ? wstrb_q  : s_axi.wstrb;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    always_comb begin
        w_next         = w_state;
        s_axi.awready  = 1'b0;
        s_axi.wready   = 1'b0;
        s_axi.bvalid   = 1'b0;
        aw_fire        = 1'b0;
        w_fire         = 1'b0;
        commit         = 1'b0;
        if (!ARESET) begin
            case (w_state)
                W_IDLE: begin
                    s_axi.awready = !aw_done;
                    s_axi.wready  = !w_done;
                    aw_fire       = s_axi.awvalid && !aw_done;
                    w_fire        = s_axi.wvalid && !w_done;
                    if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                        commit = 1'b1;
                        w_next = W_RESP;
                    end
                end
                W_RESP: begin
                    s_axi.bvalid = 1'b1;
                    if (s_axi.bready) begin
                        w_next = W_IDLE;
                    end
                end
                default: w_next = W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= RESP_OKAY;
        end else if (commit) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bresp_q <= resp_for(wr_addr);
        end else begin
            if (aw_fire) begin
                aw_done  <= 1'b1;
                awaddr_q <= s_axi.awaddr;
            end
            if (w_fire) begin
                w_done  <= 1'b1;
                wdata_q <= s_axi.wdata;
                wstrb_q <= s_axi.wstrb;
            end
        end
    end

    assign s_axi.bresp = bresp_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next        = r_state;
        s_axi.arready = 1'b0;
        s_axi.rvalid  = 1'b0;
        ar_fire       = 1'b0;
        if (!ARESET) begin
            case (r_state)
                R_IDLE: begin
                    s_axi.arready = 1'b1;
                    ar_fire       = s_axi.arvalid;
                    if (ar_fire) begin
                        r_next = R_DATA;
                    end
                end
                R_DATA: begin
                    s_axi.rvalid = 1'b1;
                    if (s_axi.rready) begin
                        r_next = R_IDLE;
                    end
                end
                default: r_next = R_IDLE;
            endcase
        end
    end

    // The bank updates on the same edge, so a read captured alongside a commit sees the old value.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_fire) begin
            rdata_q <= bank_rdata;
            rresp_q <= resp_for(s_axi.araddr);
        end
    end

    assign s_axi.rdata = rdata_q;
    assign s_axi.rresp = rresp_q;

    axi4lite_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk   (ACLK),
        .rst   (ARESET),
        .we    (commit),
        .widx  (wr_addr[AW-1:2]),
        .wdata (wr_data),
        .wstrb (wr_strb),
        .ridx  (s_axi.araddr[AW-1:2]),
        .rdata (bank_rdata),
        .regs  (regs_o)
    );

endmodule
